// File: rtl/control_sequencer_if.sv
// Datapath-side bundle of the control sequencer: IR and memory-ready in,
// per-T-step bus/load strobes and register selects out.
interface control_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int OP_W   = 5
);
  logic [DATA_W-1:0] ir;
  logic              mem_ready;
  logic              pc_out;
  logic              inc_pc;
  logic              z_in;
  logic              zlo_out;
  logic              pc_in;
  logic              mar_in;
  logic              mem_rd;
  logic              mdr_read;
  logic              mdr_in;
  logic              mdr_out;
  logic              ir_in;
  logic              y_in;
  logic [OP_W-1:0]   alu_op;
  logic [NREG-1:0]   reg_out;
  logic [NREG-1:0]   reg_in;

  modport master (
    input  ir, mem_ready,
    output pc_out, inc_pc, z_in, zlo_out, pc_in, mar_in, mem_rd, mdr_read,
           mdr_in, mdr_out, ir_in, y_in, alu_op, reg_out, reg_in
  );

  modport slave (
    output ir, mem_ready,
    input  pc_out, inc_pc, z_in, zlo_out, pc_in, mar_in, mem_rd, mdr_read,
           mdr_in, mdr_out, ir_in, y_in, alu_op, reg_out, reg_in
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T-step control unit: fetch (T0-T2), decode, and register-register
// ALU execute (T3-T5), with run/single-step control and halt/illegal stop.
module control_sequencer #(
  parameter int                   DATA_W     = 32,
  parameter int                   NREG       = 16,
  parameter int                   OP_W       = 5,
  parameter logic [2**OP_W-1:0]   RTYPE_MASK = 32'h0000_7FF8,
  parameter logic [OP_W-1:0]      HALT_OP    = 5'b11011,
  parameter logic [OP_W-1:0]      NOP_OP     = 5'b11010
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic                step,
  control_sequencer_if.master bus,
  output logic                halted,
  output logic                illegal,
  output logic                busy
);
  localparam int RF_W = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [3:0] {IDLE, T0, T1, T2, DEC, T3, T4, T5, GATE, HALT} state_t;

  typedef struct packed {
    logic pc_out, inc_pc, z_in, zlo_out, pc_in, mar_in;
    logic mem_rd, mdr_read, mdr_in, mdr_out, ir_in, y_in;
  } strobe_t;

  state_t          state, state_n;
  strobe_t         strb, strb_n;
  logic [NREG-1:0] reg_out_q, reg_out_n, reg_in_q, reg_in_n;
  logic [OP_W-1:0] alu_op_q, alu_op_n;
  logic            step_pend, step_pend_n, illegal_n;
  logic [OP_W-1:0] op;
  logic [RF_W-1:0] ra, rb, rc;

  // Operand fields sit directly below the opcode; the low IR bits are don't-care here.
  logic unused_ir_bits;
  assign unused_ir_bits = ^bus.ir;

  assign op = bus.ir[DATA_W-1 -: OP_W];
  assign ra = bus.ir[DATA_W-OP_W-1 -: RF_W];
  assign rb = bus.ir[DATA_W-OP_W-RF_W-1 -: RF_W];
  assign rc = bus.ir[DATA_W-OP_W-2*RF_W-1 -: RF_W];

  function automatic logic [NREG-1:0] onehot(input logic [RF_W-1:0] f);
    logic [NREG-1:0] v;
    logic [RF_W-1:0] idx;
    v        = '0;
    idx      = RF_W'(int'(f) % NREG);
    v[idx]   = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_n     = state;
    step_pend_n = step_pend;
    illegal_n   = illegal;
    if (step && !run) step_pend_n = 1'b1;

    case (state)
      IDLE:    if (run || step || step_pend) state_n = T0;
      T0:      state_n = T1;
      T1:      if (bus.mem_ready) state_n = T2;
      T2:      state_n = DEC;
      DEC: begin
        if (op == HALT_OP)       state_n = HALT;
        else if (op == NOP_OP)   state_n = GATE;
        else if (RTYPE_MASK[op]) state_n = T3;
        else begin
          state_n   = HALT;
          illegal_n = 1'b1;
        end
      end
      T3:      state_n = T4;
      T4:      state_n = T5;
      T5:      state_n = GATE;
      GATE: begin
        step_pend_n = 1'b0;
        state_n     = run ? T0 : IDLE;
      end
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered with it, so each
  // strobe is a clean Moore output for the whole cycle of its T-step.
  always_comb begin
    strb_n    = '0;
    reg_out_n = '0;
    reg_in_n  = '0;
    alu_op_n  = alu_op_q;

    case (state_n)
      T0: begin
        strb_n.pc_out = 1'b1;
        strb_n.mar_in = 1'b1;
        strb_n.inc_pc = 1'b1;
        strb_n.z_in   = 1'b1;
      end
      T1: begin
        strb_n.mem_rd   = 1'b1;
        strb_n.mdr_read = 1'b1;
        strb_n.mdr_in   = 1'b1;
        if (state != T1) begin
          strb_n.zlo_out = 1'b1;
          strb_n.pc_in   = 1'b1;
        end
      end
      T2: begin
        strb_n.mdr_out = 1'b1;
        strb_n.ir_in   = 1'b1;
      end
      T3: begin
        strb_n.y_in = 1'b1;
        reg_out_n   = onehot(rb);
      end
      T4: begin
        strb_n.z_in = 1'b1;
        reg_out_n   = onehot(rc);
        alu_op_n    = op;
      end
      T5: begin
        strb_n.zlo_out = 1'b1;
        reg_in_n       = onehot(ra);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      strb      <= '0;
      reg_out_q <= '0;
      reg_in_q  <= '0;
      alu_op_q  <= '0;
      step_pend <= 1'b0;
      illegal   <= 1'b0;
      halted    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      strb      <= strb_n;
      reg_out_q <= reg_out_n;
      reg_in_q  <= reg_in_n;
      alu_op_q  <= alu_op_n;
      step_pend <= step_pend_n;
      illegal   <= illegal_n;
      halted    <= (state_n == HALT);
      busy      <= (state_n != IDLE) && (state_n != HALT);
    end
  end

  assign bus.pc_out   = strb.pc_out;
  assign bus.inc_pc   = strb.inc_pc;
  assign bus.z_in     = strb.z_in;
  assign bus.zlo_out  = strb.zlo_out;
  assign bus.pc_in    = strb.pc_in;
  assign bus.mar_in   = strb.mar_in;
  assign bus.mem_rd   = strb.mem_rd;
  assign bus.mdr_read = strb.mdr_read;
  assign bus.mdr_in   = strb.mdr_in;
  assign bus.mdr_out  = strb.mdr_out;
  assign bus.ir_in    = strb.ir_in;
  assign bus.y_in     = strb.y_in;
  assign bus.alu_op   = alu_op_q;
  assign bus.reg_out  = reg_out_q;
  assign bus.reg_in   = reg_in_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: each instruction is expanded into
// its expected per-cycle strobe table and compared cycle by cycle.
module tb_control_sequencer;
  localparam int DATA_W = 32;
  localparam int NREG   = 16;
  localparam int OP_W   = 5;
  localparam logic [31:0] RTYPE = 32'h0000_7FF8;

  // Strobe order: pc_out inc_pc z_in zlo_out pc_in mar_in mem_rd mdr_read mdr_in mdr_out ir_in y_in
  localparam logic [11:0] ST_T0  = 12'b1110_0100_0000;
  localparam logic [11:0] ST_T1A = 12'b0001_1011_1000;
  localparam logic [11:0] ST_T1B = 12'b0000_0011_1000;
  localparam logic [11:0] ST_T2  = 12'b0000_0000_0110;
  localparam logic [11:0] ST_T3  = 12'b0000_0000_0001;
  localparam logic [11:0] ST_T4  = 12'b0010_0000_0000;
  localparam logic [11:0] ST_T5  = 12'b0001_0000_0000;

  typedef struct {
    logic [46:0] v;
    int          t1;
    bit          alu_chk;
    logic [4:0]  alu;
  } cyc_t;

  logic clk = 1'b0;
  logic clr, run, step;
  logic halted, illegal, busy;
  int   total = 0;
  int   bad   = 0;

  control_sequencer_if #(.DATA_W(DATA_W), .NREG(NREG), .OP_W(OP_W)) bus ();

  control_sequencer #(.DATA_W(DATA_W), .NREG(NREG), .OP_W(OP_W)) dut (
    .clk(clk), .clr(clr), .run(run), .step(step), .bus(bus),
    .halted(halted), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [46:0] got_vec();
    return {bus.pc_out, bus.inc_pc, bus.z_in, bus.zlo_out, bus.pc_in, bus.mar_in,
            bus.mem_rd, bus.mdr_read, bus.mdr_in, bus.mdr_out, bus.ir_in, bus.y_in,
            bus.reg_out, bus.reg_in, halted, illegal, busy};
  endfunction

  function automatic logic [46:0] pk(input logic [11:0] s, input logic [15:0] ro,
                                     input logic [15:0] ri, input logic h,
                                     input logic il, input logic b);
    return {s, ro, ri, h, il, b};
  endfunction

  // 0 = register-register ALU, 1 = no-op, 2 = halt, 3 = illegal
  function automatic int kind_of(input logic [4:0] op);
    if (op == 5'b11011) return 2;
    if (op == 5'b11010) return 1;
    if (RTYPE[op])      return 0;
    return 3;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] op;
    op = ($urandom_range(0, 9) < 2) ? 5'b11010 : 5'(3 + $urandom_range(0, 11));
    return {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
  endfunction

  task automatic check_idle(input string tag);
    @(posedge clk); #1;
    check_output(tag, 64'(got_vec()), 64'(pk(12'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0)));
  endtask

  task automatic do_reset(input string tag);
    clr = 1'b0; run = 1'b0; step = 1'b0;
    #2;
    check_output({tag, " async"}, 64'({got_vec(), bus.alu_op}), 64'h0);
    @(posedge clk); #1;
    clr = 1'b1;
    check_idle({tag, " idle"});
  endtask

  // Caller stands at the sample point of the cycle before T0 with run/step set.
  task automatic apply_stimulus(input string tag, input logic [31:0] iv, input int waits,
                                input int drop_k, input bit poke_step, input int halt_cycles);
    cyc_t        q[$];
    logic [15:0] ra1, rb1, rc1;
    int          kind;
    kind = kind_of(iv[31:27]);
    ra1  = 16'(1) << (int'(iv[26:23]) % NREG);
    rb1  = 16'(1) << (int'(iv[22:19]) % NREG);
    rc1  = 16'(1) << (int'(iv[18:15]) % NREG);

    q.push_back('{pk(ST_T0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1), -1, 1'b0, 5'h0});
    for (int j = 0; j <= waits; j++)
      q.push_back('{pk((j == 0) ? ST_T1A : ST_T1B, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1), j, 1'b0, 5'h0});
    q.push_back('{pk(ST_T2, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1), -1, 1'b0, 5'h0});
    q.push_back('{pk(12'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1), -1, 1'b0, 5'h0});
    if (kind == 0) begin
      q.push_back('{pk(ST_T3, rb1, 16'h0, 1'b0, 1'b0, 1'b1), -1, 1'b0, 5'h0});
      q.push_back('{pk(ST_T4, rc1, 16'h0, 1'b0, 1'b0, 1'b1), -1, 1'b1, iv[31:27]});
      q.push_back('{pk(ST_T5, 16'h0, ra1, 1'b0, 1'b0, 1'b1), -1, 1'b0, 5'h0});
    end
    if (kind <= 1)
      q.push_back('{pk(12'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1), -1, 1'b0, 5'h0});
    else
      for (int j = 0; j < halt_cycles; j++)
        q.push_back('{pk(12'h0, 16'h0, 16'h0, 1'b1, kind == 3, 1'b0), -1, 1'b0, 5'h0});

    bus.ir = iv;
    foreach (q[k]) begin
      @(posedge clk); #1;
      check_output($sformatf("%s c%0d", tag, k), 64'(got_vec()), 64'(q[k].v));
      if (q[k].alu_chk)
        check_output({tag, " alu_op"}, 64'(bus.alu_op), 64'(q[k].alu));
      step = (k == 0) && poke_step;
      bus.mem_ready = (q[k].t1 >= 0) ? (q[k].t1 >= waits) : 1'($urandom);
      if (k == drop_k) run = 1'b0;
      if (halt_cycles > 0 && k >= q.size() - halt_cycles) begin
        step = 1'($urandom);
        run  = 1'($urandom);
      end
    end
  endtask

  initial begin
    logic [31:0] iv;
    int          chain, w, len, drop;
    bit          use_step;
    logic [4:0]  bad_ops [8];
    bad_ops = '{5'd0, 5'd1, 5'd2, 5'd15, 5'd20, 5'd25, 5'd28, 5'd31};

    clr = 1'b0; run = 1'b0; step = 1'b0;
    bus.ir = '0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_output("reset", 64'({got_vec(), bus.alu_op}), 64'h0);
    clr = 1'b1;
    check_idle("idle0");

    run = 1'b1;
    apply_stimulus("rr0", 32'h5011_8000, 0, -1, 1'b0, 0);
    apply_stimulus("rr_wait3", 32'h5011_8000, 3, 10, 1'b0, 0);
    check_idle("idle1");

    step = 1'b1;
    apply_stimulus("step1", {5'b01011, 4'd5, 4'd9, 4'd15, 15'h0}, 0, -1, 1'b0, 0);
    check_idle("idle2");
    step = 1'b1;
    apply_stimulus("step2", {5'b11010, 27'h0}, 1, -1, 1'b0, 0);
    check_idle("idle3");
    step = 1'b1;
    apply_stimulus("same_regs", {5'b00011, 4'd7, 4'd7, 4'd7, 15'h0}, 2, -1, 1'b0, 0);
    check_idle("idle4");

    for (int i = 0; i < 30; i++) begin
      use_step = 1'($urandom);
      chain    = use_step ? 1 : $urandom_range(1, 3);
      if (use_step) step = 1'b1;
      else          run  = 1'b1;
      for (int c = 0; c < chain; c++) begin
        iv   = rand_instr();
        w    = $urandom_range(0, 3);
        len  = ((kind_of(iv[31:27]) == 0) ? 8 : 5) + w;
        drop = (!use_step && c == chain - 1) ? $urandom_range(1, len - 1) : -1;
        apply_stimulus($sformatf("rnd%0d_%0d", i, c), iv, w, drop,
                       !use_step && 1'($urandom), 0);
      end
      check_idle($sformatf("rnd%0d idle", i));
    end

    run = 1'b1;
    apply_stimulus("halt", {5'b11011, 27'h0}, 1, -1, 1'b0, 4);
    do_reset("rst_halt");
    run = 1'b1;
    apply_stimulus("illegal31", {5'b11111, 27'h0}, 0, -1, 1'b0, 4);
    do_reset("rst_ill");
    run = 1'b1;
    apply_stimulus("illegal_rnd", {bad_ops[$urandom_range(0, 7)], 27'($urandom)}, 1, -1, 1'b0, 3);
    do_reset("rst_ill2");

    run = 1'b1; bus.ir = 32'h5011_8000; bus.mem_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_output("t4_pre", 64'(got_vec()), 64'(pk(ST_T4, 16'h0008, 16'h0, 1'b0, 1'b0, 1'b1)));
    do_reset("rst_t4");
    run = 1'b1;
    apply_stimulus("after_rst", 32'h5011_8000, 0, 7, 1'b0, 0);
    check_idle("idle_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
